// File: rtl/arm_mainfsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// master = controller side, slave = datapath / condition stage side.
interface arm_mainfsm_if #(
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         Rd;
    logic               IRWrite;
    logic               NextPC;
    logic               AdrSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUControl;
    logic [1:0]         FlagW;
    logic               RegW;
    logic               MemW;
    logic               Branch;
    logic               PCS;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic               Undef;
    logic [STATE_W-1:0] State;

    modport master (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output ALUControl, FlagW, RegW, MemW, Branch, PCS,
        output ImmSrc, RegSrc, Undef, State
    );

    modport slave (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  ALUControl, FlagW, RegW, MemW, Branch, PCS,
        input  ImmSrc, RegSrc, Undef, State
    );
endinterface

// File: rtl/arm_mainfsm.sv
// Multicycle main controller FSM with ALU decoder.
// Strobes are unconditioned; the condition stage gates them with CondEx.
module arm_mainfsm #(
    parameter int STATE_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    arm_mainfsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       undef;
    logic       alu_op;
    logic [1:0] alu_ctrl;
    logic [1:0] flag_w;
    logic       cmd_ok;
    logic       pcs;

    // next-state selection; unused codes fall back to FETCH
    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:    state_nx = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_nx = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nx = MEMADR;
                    2'b10:   state_nx = BRANCH;
                    default: state_nx = UNKNOWN;
                endcase
            end
            MEMADR:   state_nx = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nx = MEMWB;
            EXECUTER: state_nx = ALUWB;
            EXECUTEI: state_nx = ALUWB;
            default:  state_nx = FETCH;
        endcase
    end

    // state register; async reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nx;
    end

    // Moore decode of strobes and mux selects
    always_comb begin
        ir_write = 1'b0;
        next_pc  = 1'b0;
        adr_src  = 1'b0;
        src_a    = 2'b00;
        src_b    = 2'b00;
        res_src  = 2'b00;
        reg_w    = 1'b0;
        mem_w    = 1'b0;
        branch   = 1'b0;
        undef    = 1'b0;
        alu_op   = 1'b0;
        case (state)
            FETCH: begin
                ir_write = 1'b1;
                next_pc  = 1'b1;
                src_a    = 2'b01;
                src_b    = 2'b10;
                res_src  = 2'b10;
            end
            DECODE: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                res_src = 2'b10;
            end
            MEMADR: begin
                src_b = 2'b01;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                res_src = 2'b01;
                reg_w   = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECUTER: begin
                alu_op = 1'b1;
            end
            EXECUTEI: begin
                src_b  = 2'b01;
                alu_op = 1'b1;
            end
            ALUWB: begin
                reg_w = 1'b1;
            end
            BRANCH: begin
                src_b   = 2'b01;
                res_src = 2'b10;
                branch  = 1'b1;
            end
            UNKNOWN: begin
                undef = 1'b1;
            end
            default: begin
                ir_write = 1'b0;
            end
        endcase
    end

    // ALU decoder; unsupported cmds add and leave flags untouched
    always_comb begin
        alu_ctrl = 2'b00;
        cmd_ok   = 1'b0;
        if (alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: begin alu_ctrl = 2'b00; cmd_ok = 1'b1; end
                4'b0010: begin alu_ctrl = 2'b01; cmd_ok = 1'b1; end
                4'b0000: begin alu_ctrl = 2'b10; cmd_ok = 1'b1; end
                4'b1100: begin alu_ctrl = 2'b11; cmd_ok = 1'b1; end
                default: begin alu_ctrl = 2'b00; cmd_ok = 1'b0; end
            endcase
        end
        flag_w[1] = cmd_ok & bus.Funct[0];
        flag_w[0] = cmd_ok & bus.Funct[0] & ~alu_ctrl[1];
        pcs       = ((bus.Rd == 4'hF) & reg_w) | branch;
    end

    // every output held low while reset is asserted
    assign bus.IRWrite    = reset & ir_write;
    assign bus.NextPC     = reset & next_pc;
    assign bus.AdrSrc     = reset & adr_src;
    assign bus.ALUSrcA    = reset ? src_a    : 2'b00;
    assign bus.ALUSrcB    = reset ? src_b    : 2'b00;
    assign bus.ResultSrc  = reset ? res_src  : 2'b00;
    assign bus.ALUControl = reset ? alu_ctrl : 2'b00;
    assign bus.FlagW      = reset ? flag_w   : 2'b00;
    assign bus.RegW       = reset & reg_w;
    assign bus.MemW       = reset & mem_w;
    assign bus.Branch     = reset & branch;
    assign bus.PCS        = reset & pcs;
    assign bus.ImmSrc     = reset ? bus.Op   : 2'b00;
    assign bus.RegSrc     = reset ? {bus.Op == 2'b01, bus.Op == 2'b10} : 2'b00;
    assign bus.Undef      = reset & undef;
    assign bus.State      = STATE_W'(state);

endmodule

// File: tb/tb_arm_mainfsm.sv
// Bench for arm_mainfsm: per-cycle expectation table fed through a
// scoreboard queue, plus an async reset abort in the middle of a store.
module tb_arm_mainfsm;

    localparam int STATE_W = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic reset = 1'b0;

    arm_mainfsm_if #(.STATE_W(STATE_W)) bus ();

    arm_mainfsm #(.STATE_W(STATE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  st;
        logic [21:0] vec;
    } row_t;

    row_t tbl[$];
    row_t sb[$];
    row_t str_rows[4];
    int   checks = 0;
    int   errors = 0;

    function automatic row_t mk(
        input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
        input logic [3:0] st, input logic irw, input logic npc,
        input logic adr, input logic [1:0] sa, input logic [1:0] sbs,
        input logic [1:0] rs, input logic [1:0] alu, input logic [1:0] fw,
        input logic rw, input logic mw, input logic br, input logic pcs,
        input logic und
    );
        row_t r;
        r.id    = 0;
        r.op    = op;
        r.funct = f;
        r.rd    = rd;
        r.st    = st;
        r.vec   = {irw, npc, adr, sa, sbs, rs, alu, fw, rw, mw, br, pcs,
                   op, (op == 2'b01), (op == 2'b10), und};
        return r;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.FlagW,
                bus.RegW, bus.MemW, bus.Branch, bus.PCS, bus.ImmSrc,
                bus.RegSrc, bus.Undef};
    endfunction

    // pop one expected record per falling edge and compare
    always @(negedge clk) begin
        row_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks += 2;
            if (bus.State !== STATE_W'(e.st)) begin
                errors++;
                $display("FAIL row%0d state: got %0d want %0d",
                         e.id, bus.State, e.st);
            end
            if (dut_vec() !== e.vec) begin
                errors++;
                $display("FAIL row%0d outputs: got %h want %h",
                         e.id, dut_vec(), e.vec);
            end
        end
    end

    task automatic apply(input row_t r);
        bus.Op    = r.op;
        bus.Funct = r.funct;
        bus.Rd    = r.rd;
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] st,
                       input logic [21:0] v);
        checks += 2;
        if (bus.State !== STATE_W'(st)) begin
            errors++;
            $display("FAIL %s state: got %0d want %0d", nm, bus.State, st);
        end
        if (dut_vec() !== v) begin
            errors++;
            $display("FAIL %s outputs: got %h want %h", nm, dut_vec(), v);
        end
    endtask

    task automatic add_instr(input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd);
        tbl.push_back(mk(op, f, rd, 4'd0, H, H, L, 2'b01, 2'b10, 2'b10,
                         2'b00, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(op, f, rd, 4'd1, L, L, L, 2'b01, 2'b10, 2'b10,
                         2'b00, 2'b00, L, L, L, L, L));
    endtask

    initial begin
        // ADD reg, S=1, Rd=2
        add_instr(2'b00, 6'b001001, 4'd2);
        tbl.push_back(mk(2'b00, 6'b001001, 4'd2, 4'd6, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b11, L, L, L, L, L));
        tbl.push_back(mk(2'b00, 6'b001001, 4'd2, 4'd8, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, H, L, L, L, L));
        // SUB reg, S=0, Rd=1
        add_instr(2'b00, 6'b000100, 4'd1);
        tbl.push_back(mk(2'b00, 6'b000100, 4'd1, 4'd6, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b01, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(2'b00, 6'b000100, 4'd1, 4'd8, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, H, L, L, L, L));
        // AND reg, S=1: only NZ flags written
        add_instr(2'b00, 6'b000001, 4'd5);
        tbl.push_back(mk(2'b00, 6'b000001, 4'd5, 4'd6, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b10, 2'b10, L, L, L, L, L));
        tbl.push_back(mk(2'b00, 6'b000001, 4'd5, 4'd8, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, H, L, L, L, L));
        // unsupported cmd 1010, S=1: add, no flags
        add_instr(2'b00, 6'b010101, 4'd6);
        tbl.push_back(mk(2'b00, 6'b010101, 4'd6, 4'd6, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(2'b00, 6'b010101, 4'd6, 4'd8, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, H, L, L, L, L));
        // LDR Rd=3
        add_instr(2'b01, 6'b011001, 4'd3);
        tbl.push_back(mk(2'b01, 6'b011001, 4'd3, 4'd2, L, L, L, 2'b00,
                         2'b01, 2'b00, 2'b00, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(2'b01, 6'b011001, 4'd3, 4'd3, L, L, H, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(2'b01, 6'b011001, 4'd3, 4'd4, L, L, L, 2'b00,
                         2'b00, 2'b01, 2'b00, 2'b00, H, L, L, L, L));
        // LDR into PC
        add_instr(2'b01, 6'b011001, 4'd15);
        tbl.push_back(mk(2'b01, 6'b011001, 4'd15, 4'd2, L, L, L, 2'b00,
                         2'b01, 2'b00, 2'b00, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(2'b01, 6'b011001, 4'd15, 4'd3, L, L, H, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(2'b01, 6'b011001, 4'd15, 4'd4, L, L, L, 2'b00,
                         2'b00, 2'b01, 2'b00, 2'b00, H, L, L, H, L));
        // STR
        add_instr(2'b01, 6'b011000, 4'd4);
        tbl.push_back(mk(2'b01, 6'b011000, 4'd4, 4'd2, L, L, L, 2'b00,
                         2'b01, 2'b00, 2'b00, 2'b00, L, L, L, L, L));
        tbl.push_back(mk(2'b01, 6'b011000, 4'd4, 4'd5, L, L, H, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, L, H, L, L, L));
        for (int i = 0; i < 4; i++) str_rows[i] = tbl[tbl.size() - 4 + i];
        // ORR immediate, S=1, Rd=15
        add_instr(2'b00, 6'b111001, 4'd15);
        tbl.push_back(mk(2'b00, 6'b111001, 4'd15, 4'd7, L, L, L, 2'b00,
                         2'b01, 2'b00, 2'b11, 2'b10, L, L, L, L, L));
        tbl.push_back(mk(2'b00, 6'b111001, 4'd15, 4'd8, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, H, L, L, H, L));
        // B
        add_instr(2'b10, 6'b101010, 4'd0);
        tbl.push_back(mk(2'b10, 6'b101010, 4'd0, 4'd9, L, L, L, 2'b00,
                         2'b01, 2'b10, 2'b00, 2'b00, L, L, H, H, L));
        // undefined opcode
        add_instr(2'b11, 6'b000000, 4'd0);
        tbl.push_back(mk(2'b11, 6'b000000, 4'd0, 4'd10, L, L, L, 2'b00,
                         2'b00, 2'b00, 2'b00, 2'b00, L, L, L, L, H));
        for (int i = 0; i < tbl.size(); i++) tbl[i].id = i;
        for (int i = 0; i < 4; i++) str_rows[i].id = 100 + i;

        // hold reset with live-looking inputs: all outputs must stay low
        bus.Op    = 2'b01;
        bus.Funct = 6'b011000;
        bus.Rd    = 4'd15;
        #12;
        chk("reset_hold", 4'd0, 22'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // abort a store in MEMWRITE with an asynchronous reset
        apply(str_rows[0]);
        apply(str_rows[1]);
        apply(str_rows[2]);
        bus.Op    = str_rows[3].op;
        bus.Funct = str_rows[3].funct;
        bus.Rd    = str_rows[3].rd;
        sb.push_back(str_rows[3]);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", 4'd0, 22'd0);
        @(posedge clk);
        #1;
        chk("rst_edge", 4'd0, 22'd0);
        #1;
        reset = 1'b1;
        apply(str_rows[0]);
        apply(str_rows[1]);
        apply(str_rows[2]);
        apply(str_rows[3]);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_mainfsm.md
Name: arm_mainfsm

Overview:
- Multicycle main controller FSM with ALU decoder. Sits directly upstream of the condition-logic stage.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Produces the unconditioned strobes FlagW, PCS, RegW, MemW and Branch, which the condition stage then gates with CondEx.
- Also drives the datapath mux selects and the IR/PC write enables.

Parameters:
STATE_W, 4, width of the state register and of the State debug output.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (asserted when 0)
Op  in  2  instr[27:26], taken from the instruction register
Funct  in  6  instr[25:20]; Funct[5]=I, Funct[4:1]=cmd, Funct[0]=S/L
Rd  in  4  instr[15:12]
IRWrite  out  1  instruction register load enable
NextPC  out  1  PC update enable (unconditional part)
AdrSrc  out  1  memory address select: 0=PC, 1=Result
ALUSrcA  out  2  ALU A select: 00=reg A, 01=PC, 10=ALUOut
ALUSrcB  out  2  ALU B select: 00=reg WD, 01=ExtImm, 10=const 4
ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
FlagW  out  2  flag write request: [1]=NZ, [0]=CV
RegW  out  1  register write request
MemW  out  1  memory write request
Branch  out  1  branch request
PCS  out  1  PC-write-via-Rd=15 or branch request
ImmSrc  out  2  extender mode, equal to Op
RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
Undef  out  1  undefined-opcode pulse
State  out  STATE_W  current state code, for debug

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Codes 11-15 are illegal: outputs all 0, next state FETCH.
- Reset (reset=0, async): state=FETCH; every strobe and select output is forced to 0 while reset is low. Reset at any point mid-instruction abandons that instruction; no RegW/MemW is issued for it.
- After reset releases, the first rising edge occurs in FETCH with its outputs active.
- Outputs are Moore-decoded from the state, except FlagW, ALUControl, PCS, ImmSrc and RegSrc, which also depend on the inputs. All unlisted outputs are 0 in each state.
- Transitions and outputs per state:
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1 -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by Op: 01 -> MEMADR; 00 with Funct[5]=0 -> EXECUTER; 00 with Funct[5]=1 -> EXECUTEI; 10 -> BRANCH; 11 -> UNKNOWN.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALU add. Funct[0]=1 -> MEMREAD; 0 -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB: ResultSrc=01, RegW=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 -> FETCH.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1 -> ALUWB.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 -> ALUWB.
  - ALUWB: ResultSrc=00, RegW=1 -> FETCH.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1, ALU add -> FETCH.
  - UNKNOWN: Undef=1 for one cycle, no other strobes -> FETCH.
- Latency (instruction to next FETCH): data-processing 4 cycles, LDR 5, STR 4, B 3, undefined 3.
- ALU decoder:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, by cmd: 0100 -> 00; 0010 -> 01; 0000 -> 10; 1100 -> 11; any other cmd -> ALUControl=00 and FlagW=00.
  - For a supported cmd: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 00 or 01).
  - FlagW is therefore nonzero only in EXECUTER/EXECUTEI.
- PCS = ((Rd==4'hF) & RegW) | Branch, so PCS pulses only in MEMWB, ALUWB or BRANCH.
- Op, Funct and Rd must stay stable from DECODE until return to FETCH (the IR is only loaded in FETCH). The block does not register them.

Test Plan:
- ADD r, S=1 (Op=00, Funct=001001, Rd=2): states 0,1,6,8,0. In state 6: ALUControl=00, FlagW=11. In state 8: RegW=1, PCS=0.
- LDR (Op=01, Funct=011001): states 0,1,2,3,4,0. AdrSrc=1 in state 3. ResultSrc=01 and RegW=1 in state 4. MemW never asserted.
- STR (Op=01, Funct=011000): states 0,1,2,5,0. MemW=1 only in state 5. RegW never asserted.
- ORR immediate, Rd=15 (Op=00, Funct=111001): states 0,1,7,8. In state 7: FlagW=10. In state 8: RegW=1, PCS=1.
- B (Op=10): states 0,1,9,0. Branch=1 and PCS=1 in state 9. ImmSrc=10, RegSrc=01 throughout.
- Op=11 gives states 0,1,10,0 with a 1-cycle Undef pulse. Separately, pull reset low during MEMWRITE (state 5): State=0 and MemW=0 immediately (async). After release, FETCH outputs resume on the next edge.
